rhythm_judge_multilane: RTL and testbench
=========================================

# rhythm_judge_multilane

Parametrised multi-lane judgement engine for the rhythm game. It sits between the game clock, the pattern source and the user-input latch. It replaces the single-lane score calculator with per-lane note queues, timing windows (perfect / good / miss), combo tracking and a saturating score. Its score output feeds the 7-segment decoder, and its per-lane hit flags drive the pattern display.

## Interface

Parameters:
- LANES, 8, number of input lanes / key bits
- DEPTH, 4, note queue entries per lane (power of two)
- TIMER_W, 10, game timer width
- WIN_PERFECT, 1, perfect half-window in game steps
- WIN_GOOD, 3, good half-window in game steps (> WIN_PERFECT)
- SCORE_W, 16, score width
- COMBO_W, 8, combo width

Ports:
- CLOCK50M  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear: queues, score, combo, flags
- game_run  in  1  judgement enabled when high (pause when low)
- game_tick  in  1  one-cycle pulse per game step
- game_timer  in  TIMER_W  current game step, wraps modulo 2^TIMER_W
- note_valid  in  1  note push request
- note_lane  in  clog2(LANES)  target lane
- note_time  in  TIMER_W  scheduled step of the note
- note_ready  out  1  target lane queue not full
- user_key  in  LANES  level of each lane key
- judge_perfect / judge_good / judge_miss  out  LANES each  one-cycle judgement pulses per lane
- score  out  SCORE_W  accumulated score, saturating
- combo  out  COMBO_W  current combo, saturating
- max_combo  out  COMBO_W  highest combo since reset/clear
- overflow  out  1  sticky: push attempted into a full queue

## Operation

- Push:
  - Accepted when note_valid && note_ready.
  - note_ready reflects the target lane's registered full state; a same-cycle pop does not free space.
  - A push into a full queue is dropped and sets overflow.
- Press detection: press[i] = user_key[i] && !key_prev[i]. key_prev is registered every cycle.
- Timing difference: d = signed(game_timer − head_time[i]), computed mod 2^TIMER_W and interpreted as a TIMER_W-bit signed value.
- Press evaluation, only when game_run:
  - Lane empty: press ignored.
  - |d| ≤ WIN_PERFECT: perfect, pop.
  - |d| ≤ WIN_GOOD: good, pop.
  - Otherwise: ignored, no penalty.
- Expiry: when game_run && game_tick && lane non-empty && d > WIN_GOOD, the lane reports miss and pops.
- Press and expiry on the same lane in the same cycle: the press result applies. The two are mutually exclusive by window, so at most one pop per lane per cycle.
- Lanes are evaluated in parallel. With hits = popcount(perfect|good) and anymiss = |miss:
  - score += 3·popcount(perfect) + 1·popcount(good), saturating at all-ones.
  - combo_next = (anymiss ? 0 : combo) + hits, saturating.
  - max_combo = max(max_combo, combo_next).
- When game_run is low: no judgement, no expiry, key_prev still tracks; pushes are still accepted.
- clear: empties all queues, zeroes score, combo, max_combo and overflow, and clears key_prev to the current user_key so that held keys generate no press.

## Timing

- Reset values: every output 0 except note_ready = 1. Queues empty.
- Key rising between edges N−1 and N is seen at edge N. The judge pulse and the score/combo update are both visible after edge N+1, i.e. 1 cycle of latency from the sampled press.
- Expiry: judge_miss asserts the cycle after the game_tick cycle.
- Judge pulses are exactly one cycle wide.
- Reset asserted mid-operation clears all state immediately. Outputs follow on the next edge after reset deasserts, with no pending pulses.
- clear has priority over push and judgement in the same cycle.

## Structure

- Shared package rhythm_pkg:
  - judge kind enum: NONE, PERFECT, GOOD, MISS.
  - point constants: PTS_PERFECT = 3, PTS_GOOD = 1.
  - clog2 helper.
- Sub-module lane_note_fifo:
  - DEPTH × TIMER_W circular queue with push, pop, clear, head, full and empty.
  - Pointers are one bit wider than the address.
  - Instantiated LANES times via generate.
- Top level holds edge detection, window compare, popcount/accumulation and saturation.

## Test plan

- Perfect hit: push lane 0 note at 100; press lane 0 at timer 100 → judge_perfect[0] pulse, score 3, combo 1, max_combo 1.
- Good and expiry: push lane 2 notes at 100 and 110; press at timer 102 → good, score +1, combo +1. Tick up to timer 114 without a press → judge_miss[2] at the tick of timer 114, combo 0, max_combo retained.
- Wrap-around: TIMER_W = 10, note at 1022, press at timer 0 → d = +2, good. Note at 1023, tick at timer 3 → d = +4, miss.
- Full queue: push 5 notes into lane 1 (DEPTH 4) → 5th dropped, note_ready low on the 5th cycle, overflow = 1. After one pop, note_ready = 1.
- Simultaneous lanes: combo 5; perfect on lanes 0 and 3 plus a miss on lane 5 in the same cycle → score +6, combo 2.
- Saturation and reset: preload score near 65535 and combo 255 → both hold at max. Assert reset mid-game → all outputs 0, note_ready 1. Held keys after clear → no judge pulse.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared types and constants for the multi-lane rhythm judgement engine.
package rhythm_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PERFECT = 2'd1,
    GOOD    = 2'd2,
    MISS    = 2'd3
  } judge_kind_e;

  localparam int PTS_PERFECT = 3;
  localparam int PTS_GOOD    = 1;

  // Address width for a count of items; never returns less than 1 bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/lane_note_fifo.sv
// Per-lane circular note queue holding the scheduled game step of each pending note.
module lane_note_fifo
  import rhythm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit separates a full queue from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rhythm_judge_multilane.sv
// Multi-lane rhythm judge: per-lane note queues, perfect/good/miss windows,
// combo tracking and a saturating score.
module rhythm_judge_multilane
  import rhythm_pkg::*;
#(
  parameter int LANES       = 8,
  parameter int DEPTH       = 4,
  parameter int TIMER_W     = 10,
  parameter int WIN_PERFECT = 1,
  parameter int WIN_GOOD    = 3,
  parameter int SCORE_W     = 16,
  parameter int COMBO_W     = 8
) (
  input  logic                      CLOCK50M,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      game_run,
  input  logic                      game_tick,
  input  logic [TIMER_W-1:0]        game_timer,
  input  logic                      note_valid,
  input  logic [clog2(LANES)-1:0]   note_lane,
  input  logic [TIMER_W-1:0]        note_time,
  output logic                      note_ready,
  input  logic [LANES-1:0]          user_key,
  output logic [LANES-1:0]          judge_perfect,
  output logic [LANES-1:0]          judge_good,
  output logic [LANES-1:0]          judge_miss,
  output logic [SCORE_W-1:0]        score,
  output logic [COMBO_W-1:0]        combo,
  output logic [COMBO_W-1:0]        max_combo,
  output logic                      overflow
);

  localparam int LANE_W = clog2(LANES);
  localparam int SUM_W  = SCORE_W + LANE_W + 3;
  localparam int CSUM_W = COMBO_W + LANE_W + 1;

  localparam logic [TIMER_W-1:0] WIN_PERFECT_T = TIMER_W'(WIN_PERFECT);
  localparam logic [TIMER_W-1:0] WIN_GOOD_T    = TIMER_W'(WIN_GOOD);
  localparam logic [SUM_W-1:0]   SCORE_CAP     = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
  localparam logic [CSUM_W-1:0]  COMBO_CAP     = {{(CSUM_W-COMBO_W){1'b0}}, {COMBO_W{1'b1}}};

  logic [LANES-1:0]   key_s;
  logic [LANES-1:0]   key_prev;
  logic [LANES-1:0]   press;
  logic [LANES-1:0]   lane_full;
  logic [LANES-1:0]   lane_empty;
  logic [LANES-1:0]   lane_push;
  logic [LANES-1:0]   lane_pop;
  logic [TIMER_W-1:0] head_time [LANES];
  logic [LANES-1:0]   hit_perfect;
  logic [LANES-1:0]   hit_good;
  logic [LANES-1:0]   hit_miss;
  logic               push_ok;

  int                 n_perfect;
  int                 n_good;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
  logic [CSUM_W-1:0]  combo_sum;
  logic [COMBO_W-1:0] combo_next;
  logic [COMBO_W-1:0] max_next;

  // Note handshake: a note transfers on a cycle with note_valid && note_ready.
  // note_ready depends only on the addressed lane's registered full flag, never
  // on note_valid or on a pop in the same cycle.
  assign note_ready = !lane_full[note_lane];
  assign push_ok    = note_valid && note_ready && !clear;

  // key_s is the sampled key level; a press is a rise between two samples.
  assign press = key_s & ~key_prev;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [TIMER_W-1:0] diff;
    logic [TIMER_W-1:0] mag;
    logic               late;
    judge_kind_e        kind;

    // diff is timer minus head modulo 2^TIMER_W, read as a signed quantity.
    assign lane_push[i] = push_ok && (note_lane == LANE_W'(i));
    assign diff         = game_timer - head_time[i];
    assign mag          = diff[TIMER_W-1] ? -diff : diff;
    assign late         = !diff[TIMER_W-1] && (diff > WIN_GOOD_T);

    always_comb begin
      kind = NONE;
      if (game_run && !lane_empty[i]) begin
        if (press[i] && (mag <= WIN_PERFECT_T))   kind = PERFECT;
        else if (press[i] && (mag <= WIN_GOOD_T)) kind = GOOD;
        else if (game_tick && late)               kind = MISS;
      end
    end

    assign hit_perfect[i] = (kind == PERFECT);
    assign hit_good[i]    = (kind == GOOD);
    assign hit_miss[i]    = (kind == MISS);
    assign lane_pop[i]    = (kind != NONE);

    lane_note_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (TIMER_W)
    ) u_fifo (
      .clk   (CLOCK50M),
      .rst   (reset),
      .clear (clear),
      .push  (lane_push[i]),
      .pop   (lane_pop[i]),
      .din   (note_time),
      .head  (head_time[i]),
      .full  (lane_full[i]),
      .empty (lane_empty[i])
    );
  end

  always_comb begin
    n_perfect  = $countones(hit_perfect);
    n_good     = $countones(hit_good);
    score_sum  = SUM_W'(score) + SUM_W'(PTS_PERFECT * n_perfect) + SUM_W'(PTS_GOOD * n_good);
    score_next = (score_sum > SCORE_CAP) ? '1 : score_sum[SCORE_W-1:0];
    // Any miss this cycle breaks the old combo before this cycle's hits count.
    combo_sum  = ((|hit_miss) ? '0 : CSUM_W'(combo)) + CSUM_W'(n_perfect + n_good);
    combo_next = (combo_sum > COMBO_CAP) ? '1 : combo_sum[COMBO_W-1:0];
    max_next   = (combo_next > max_combo) ? combo_next : max_combo;
  end

  always_ff @(posedge CLOCK50M or posedge reset) begin
    if (reset) begin
      key_s         <= '0;
      key_prev      <= '0;
      judge_perfect <= '0;
      judge_good    <= '0;
      judge_miss    <= '0;
      score         <= '0;
      combo         <= '0;
      max_combo     <= '0;
      overflow      <= 1'b0;
    end else if (clear) begin
      // Keys already held at clear must not count as fresh presses.
      key_s         <= user_key;
      key_prev      <= user_key;
      judge_perfect <= '0;
      judge_good    <= '0;
      judge_miss    <= '0;
      score         <= '0;
      combo         <= '0;
      max_combo     <= '0;
      overflow      <= 1'b0;
    end else begin
      key_s         <= user_key;
      key_prev      <= key_s;
      judge_perfect <= hit_perfect;
      judge_good    <= hit_good;
      judge_miss    <= hit_miss;
      score         <= score_next;
      combo         <= combo_next;
      max_combo     <= max_next;
      if (note_valid && lane_full[note_lane]) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rhythm_judge_multilane.sv
// Bench for rhythm_judge_multilane: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_rhythm_judge_multilane;

  localparam int LANES       = 8;
  localparam int DEPTH       = 4;
  localparam int TIMER_W     = 10;
  localparam int WIN_PERFECT = 1;
  localparam int WIN_GOOD    = 3;
  localparam int SCORE_W     = 16;
  localparam int COMBO_W     = 8;
  localparam int TMOD        = 1 << TIMER_W;
  localparam int SCORE_MAX   = (1 << SCORE_W) - 1;
  localparam int COMBO_MAX   = (1 << COMBO_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic               clr;
  logic               run;
  logic               tick;
  logic [TIMER_W-1:0] timer;
  logic               nv;
  logic [2:0]         lane;
  logic [TIMER_W-1:0] ntime;
  logic               nready;
  logic [LANES-1:0]   key;
  logic [LANES-1:0]   jp;
  logic [LANES-1:0]   jg;
  logic [LANES-1:0]   jm;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [COMBO_W-1:0] maxc;
  logic               ovf;

  always #5 clk = ~clk;

  rhythm_judge_multilane #(
    .LANES(LANES), .DEPTH(DEPTH), .TIMER_W(TIMER_W), .WIN_PERFECT(WIN_PERFECT),
    .WIN_GOOD(WIN_GOOD), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)
  ) dut (
    .CLOCK50M      (clk),
    .reset         (rst),
    .clear         (clr),
    .game_run      (run),
    .game_tick     (tick),
    .game_timer    (timer),
    .note_valid    (nv),
    .note_lane     (lane),
    .note_time     (ntime),
    .note_ready    (nready),
    .user_key      (key),
    .judge_perfect (jp),
    .judge_good    (jg),
    .judge_miss    (jm),
    .score         (score),
    .combo         (combo),
    .max_combo     (maxc),
    .overflow      (ovf)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int               mq [LANES][$];
  logic [LANES-1:0] m_k1, m_k2;
  logic [LANES-1:0] m_perf, m_good, m_miss;
  int               m_score, m_combo, m_maxc;
  bit               m_ovf;

  task automatic model_clear();
    for (int l = 0; l < LANES; l++) mq[l].delete();
    m_perf = '0; m_good = '0; m_miss = '0;
    m_score = 0; m_combo = 0; m_maxc = 0; m_ovf = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_k1 = '0; m_k2 = '0;
  endtask

  function automatic int sdiff(input int t, input int h);
    int v;
    v = (t - h + TMOD) % TMOD;
    if (v >= TMOD / 2) v -= TMOD;
    return v;
  endfunction

  // One clock edge of behaviour, using the inputs held during the cycle.
  task automatic model_step();
    logic [LANES-1:0] press;
    int d, ad, np, ng;
    bit ready;
    if (clr) begin
      model_clear();
      m_k1 = key; m_k2 = key;
      return;
    end
    ready  = mq[lane].size() < DEPTH;
    press  = m_k1 & ~m_k2;
    m_perf = '0; m_good = '0; m_miss = '0;
    for (int l = 0; l < LANES; l++) begin
      if (run && mq[l].size() > 0) begin
        d  = sdiff(int'(timer), mq[l][0]);
        ad = (d < 0) ? -d : d;
        if (press[l] && ad <= WIN_PERFECT) begin
          m_perf[l] = 1'b1; void'(mq[l].pop_front());
        end else if (press[l] && ad <= WIN_GOOD) begin
          m_good[l] = 1'b1; void'(mq[l].pop_front());
        end else if (tick && d > WIN_GOOD) begin
          m_miss[l] = 1'b1; void'(mq[l].pop_front());
        end
      end
    end
    if (nv) begin
      if (ready) mq[lane].push_back(int'(ntime));
      else m_ovf = 1;
    end
    np = $countones(m_perf);
    ng = $countones(m_good);
    m_score = m_score + 3 * np + ng;
    if (m_score > SCORE_MAX) m_score = SCORE_MAX;
    m_combo = ((m_miss != '0) ? 0 : m_combo) + np + ng;
    if (m_combo > COMBO_MAX) m_combo = COMBO_MAX;
    if (m_combo > m_maxc) m_maxc = m_combo;
    m_k2 = m_k1;
    m_k1 = key;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".perfect"}, jp, m_perf);
    check({tag, ".good"}, jg, m_good);
    check({tag, ".miss"}, jm, m_miss);
    check({tag, ".score"}, score, m_score);
    check({tag, ".combo"}, combo, m_combo);
    check({tag, ".max_combo"}, maxc, m_maxc);
    check({tag, ".overflow"}, ovf, m_ovf);
    check({tag, ".note_ready"}, nready, mq[lane].size() < DEPTH);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_cycle(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_model(tag);
  endtask

  task automatic set_in(input bit c, input bit r, input bit t, input int tm,
                        input bit v, input int ln, input int nt, input logic [7:0] k);
    clr = c; run = r; tick = t; timer = TIMER_W'(tm);
    nv = v; lane = 3'(ln); ntime = TIMER_W'(nt); key = k;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit c; bit r; bit t; int tm; bit v; int ln; int nt; logic [7:0] k;
    logic [7:0] e_p; logic [7:0] e_g; logic [7:0] e_m; int e_s; int e_c; int e_mx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit c, input bit r, input bit t, input int tm,
                              input bit v, input int ln, input int nt, input logic [7:0] k,
                              input logic [7:0] e_p, input logic [7:0] e_g, input logic [7:0] e_m,
                              input int e_s, input int e_c, input int e_mx);
    vec_t x;
    x.c = c; x.r = r; x.t = t; x.tm = tm; x.v = v; x.ln = ln; x.nt = nt; x.k = k;
    x.e_p = e_p; x.e_g = e_g; x.e_m = e_m; x.e_s = e_s; x.e_c = e_c; x.e_mx = e_mx;
    return x;
  endfunction

  initial begin
    // ---- reset ----
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00);
    rst = 1'b1;
    model_reset();
    #1;
    check("reset.outputs", {jp, jg, jm, score, combo, maxc, ovf}, '0);
    check("reset.note_ready", nready, 1);
    step_cycle("reset");
    step_cycle("reset");
    rst = 1'b0;

    // ---- directed table: perfect, good, expiry, wrap-around, early side, pause ----
    //              c r t  tm    v ln nt    key     p      g      m     s  c mx
    tbl.push_back(mk(1,1,0, 100, 0,0,0,    8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 100, 1,0,100,  8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 100, 1,2,100,  8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 100, 1,2,110,  8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 100, 0,0,0,    8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 100, 0,0,0,    8'h01, 8'h01, 8'h00, 8'h00, 3, 1, 1));
    tbl.push_back(mk(0,1,0, 102, 0,0,0,    8'h00, 8'h00, 8'h00, 8'h00, 3, 1, 1));
    tbl.push_back(mk(0,1,0, 102, 0,0,0,    8'h04, 8'h00, 8'h00, 8'h00, 3, 1, 1));
    tbl.push_back(mk(0,1,0, 102, 0,0,0,    8'h04, 8'h00, 8'h04, 8'h00, 4, 2, 2));
    tbl.push_back(mk(0,1,1, 113, 0,0,0,    8'h00, 8'h00, 8'h00, 8'h00, 4, 2, 2));
    tbl.push_back(mk(0,1,1, 114, 0,0,0,    8'h00, 8'h00, 8'h00, 8'h04, 4, 0, 2));
    tbl.push_back(mk(0,1,0, 114, 0,0,0,    8'h00, 8'h00, 8'h00, 8'h00, 4, 0, 2));
    tbl.push_back(mk(0,1,0, 1020,1,3,1022, 8'h00, 8'h00, 8'h00, 8'h00, 4, 0, 2));
    tbl.push_back(mk(0,1,0, 0,   0,0,0,    8'h08, 8'h00, 8'h00, 8'h00, 4, 0, 2));
    tbl.push_back(mk(0,1,0, 0,   0,0,0,    8'h08, 8'h00, 8'h08, 8'h00, 5, 1, 2));
    tbl.push_back(mk(0,1,0, 0,   1,3,1023, 8'h00, 8'h00, 8'h00, 8'h00, 5, 1, 2));
    tbl.push_back(mk(0,1,1, 2,   0,0,0,    8'h00, 8'h00, 8'h00, 8'h00, 5, 1, 2));
    tbl.push_back(mk(0,1,1, 3,   0,0,0,    8'h00, 8'h00, 8'h00, 8'h08, 5, 0, 2));
    tbl.push_back(mk(0,1,0, 3,   0,0,0,    8'h00, 8'h00, 8'h00, 8'h00, 5, 0, 2));
    tbl.push_back(mk(0,1,0, 46,  1,4,50,   8'h00, 8'h00, 8'h00, 8'h00, 5, 0, 2));
    tbl.push_back(mk(0,1,0, 46,  0,0,0,    8'h10, 8'h00, 8'h00, 8'h00, 5, 0, 2));
    tbl.push_back(mk(0,1,0, 46,  0,0,0,    8'h10, 8'h00, 8'h00, 8'h00, 5, 0, 2));
    tbl.push_back(mk(0,1,0, 49,  0,0,0,    8'h00, 8'h00, 8'h00, 8'h00, 5, 0, 2));
    tbl.push_back(mk(0,1,0, 49,  0,0,0,    8'h10, 8'h00, 8'h00, 8'h00, 5, 0, 2));
    tbl.push_back(mk(0,1,0, 49,  0,0,0,    8'h10, 8'h10, 8'h00, 8'h00, 8, 1, 2));
    tbl.push_back(mk(0,1,0, 49,  0,0,0,    8'h00, 8'h00, 8'h00, 8'h00, 8, 1, 2));
    tbl.push_back(mk(0,1,0, 49,  1,5,49,   8'h00, 8'h00, 8'h00, 8'h00, 8, 1, 2));
    tbl.push_back(mk(0,0,0, 49,  0,0,0,    8'h20, 8'h00, 8'h00, 8'h00, 8, 1, 2));
    tbl.push_back(mk(0,0,0, 49,  0,0,0,    8'h20, 8'h00, 8'h00, 8'h00, 8, 1, 2));
    tbl.push_back(mk(0,1,0, 49,  0,0,0,    8'h00, 8'h00, 8'h00, 8'h00, 8, 1, 2));
    tbl.push_back(mk(0,1,0, 49,  0,0,0,    8'h20, 8'h00, 8'h00, 8'h00, 8, 1, 2));
    tbl.push_back(mk(0,1,0, 49,  0,0,0,    8'h20, 8'h20, 8'h00, 8'h00, 11, 2, 2));
    tbl.push_back(mk(0,1,0, 49,  0,0,0,    8'h00, 8'h00, 8'h00, 8'h00, 11, 2, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].c, tbl[i].r, tbl[i].t, tbl[i].tm, tbl[i].v, tbl[i].ln, tbl[i].nt, tbl[i].k);
      step_cycle($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.perfect", i), jp, tbl[i].e_p);
      check($sformatf("tbl%0d.good", i), jg, tbl[i].e_g);
      check($sformatf("tbl%0d.miss", i), jm, tbl[i].e_m);
      check($sformatf("tbl%0d.score", i), score, tbl[i].e_s);
      check($sformatf("tbl%0d.combo", i), combo, tbl[i].e_c);
      check($sformatf("tbl%0d.max_combo", i), maxc, tbl[i].e_mx);
    end

    // ---- full queue on lane 1 ----
    set_in(1, 1, 0, 300, 0, 1, 0, 8'h00);
    step_cycle("full.clr");
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 0, 300, 1, 1, 300, 8'h00);
      #1;
      check($sformatf("full.ready%0d", i), nready, (i < 4) ? 1 : 0);
      step_cycle("full.push");
    end
    check("full.overflow", ovf, 1);
    set_in(0, 1, 0, 300, 0, 1, 0, 8'h02);
    step_cycle("full.key");
    set_in(0, 1, 0, 300, 0, 1, 0, 8'h00);
    #1;
    check("full.ready_same_cycle_pop", nready, 0);
    step_cycle("full.pop");
    check("full.pop_perfect", jp, 8'h02);
    check("full.ready_after_pop", nready, 1);

    // ---- simultaneous lanes: combo 5, then two perfects and a miss together ----
    set_in(1, 1, 0, 200, 0, 0, 0, 8'h00);
    step_cycle("sim.clr");
    for (int l = 0; l < 5; l++) begin
      set_in(0, 1, 0, 200, 1, l, 200, 8'h00);
      step_cycle("sim.push");
    end
    set_in(0, 1, 0, 200, 0, 0, 0, 8'h1f);
    step_cycle("sim.key");
    set_in(0, 1, 0, 200, 0, 0, 0, 8'h00);
    step_cycle("sim.hit5");
    check("sim.combo5", combo, 5);
    check("sim.score15", score, 15);
    set_in(0, 1, 0, 200, 1, 0, 200, 8'h00); step_cycle("sim.push");
    set_in(0, 1, 0, 200, 1, 3, 200, 8'h00); step_cycle("sim.push");
    set_in(0, 1, 0, 200, 1, 5, 190, 8'h00); step_cycle("sim.push");
    set_in(0, 1, 0, 200, 0, 0, 0, 8'h09);   step_cycle("sim.key");
    set_in(0, 1, 1, 200, 0, 0, 0, 8'h00);   step_cycle("sim.judge");
    check("sim.perfect", jp, 8'h09);
    check("sim.miss", jm, 8'h20);
    check("sim.score21", score, 21);
    check("sim.combo2", combo, 2);
    check("sim.max5", maxc, 5);

    // ---- held keys across clear, clear priority over push ----
    set_in(0, 1, 0, 200, 0, 0, 0, 8'h40); step_cycle("held.key");
    step_cycle("held.key");
    set_in(1, 1, 0, 200, 0, 0, 0, 8'h40); step_cycle("held.clr");
    set_in(0, 1, 0, 200, 1, 6, 200, 8'h40); step_cycle("held.push");
    set_in(0, 1, 0, 200, 0, 0, 0, 8'h40);
    for (int i = 0; i < 3; i++) begin
      step_cycle("held.idle");
      check("held.nojudge", jp | jg | jm, 0);
    end
    set_in(0, 1, 0, 200, 0, 0, 0, 8'h00); step_cycle("held.rel");
    set_in(0, 1, 0, 200, 0, 0, 0, 8'h40); step_cycle("held.key");
    step_cycle("held.press");
    check("held.repress", jp, 8'h40);
    set_in(1, 1, 0, 200, 1, 7, 200, 8'h00); step_cycle("clrpri.clr");
    set_in(0, 1, 0, 200, 0, 7, 0, 8'h80);   step_cycle("clrpri.key");
    set_in(0, 1, 0, 200, 0, 7, 0, 8'h00);   step_cycle("clrpri.press");
    check("clrpri.nojudge", jp | jg, 0);

    // ---- saturation of score and combo ----
    set_in(1, 1, 0, 300, 0, 0, 0, 8'h00);
    step_cycle("sat.clr");
    for (int r = 0; r < 2735; r++) begin
      for (int l = 0; l < LANES; l++) begin
        set_in(0, 1, 0, 300, 1, l, 300, 8'h00);
        step_cycle("sat.push");
      end
      set_in(0, 1, 0, 300, 0, 0, 0, 8'hff); step_cycle("sat.key");
      set_in(0, 1, 0, 300, 0, 0, 0, 8'h00); step_cycle("sat.hit");
    end
    check("sat.score", score, SCORE_MAX);
    check("sat.combo", combo, COMBO_MAX);
    check("sat.max_combo", maxc, COMBO_MAX);

    // ---- reset mid-game with a press pending ----
    set_in(0, 1, 0, 300, 1, 0, 300, 8'h00); step_cycle("rst.push");
    set_in(0, 1, 0, 300, 0, 0, 0, 8'h01);   step_cycle("rst.key");
    rst = 1'b1;
    key = 8'h00;
    model_reset();
    #2;
    check("rst.async_outputs", {jp, jg, jm, score, combo, maxc, ovf}, '0);
    check("rst.async_ready", nready, 1);
    step_cycle("rst.hold");
    step_cycle("rst.hold");
    rst = 1'b0;
    step_cycle("rst.after");
    step_cycle("rst.after");
    check("rst.no_pending", jp | jg | jm, 0);

    // ---- randomized traffic against the model ----
    set_in(1, 1, 0, 1000, 0, 0, 0, 8'h00);
    step_cycle("rand.clr");
    for (int c = 0; c < 4000; c++) begin
      clr  = ($urandom_range(0, 299) == 0);
      run  = ($urandom_range(0, 9) != 0);
      tick = ($urandom_range(0, 3) == 0);
      if (tick) timer = timer + 1'b1;
      nv    = ($urandom_range(0, 2) == 0);
      lane  = 3'($urandom_range(0, LANES - 1));
      ntime = TIMER_W'((int'(timer) + $urandom_range(0, 10) + TMOD - 2) % TMOD);
      key   = key ^ 8'($urandom & $urandom);
      step_cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
